// File: rtl/bus_initiator.sv
// Initiator side of the shared single-bus memory protocol: queues core requests
// in a small FIFO and sequences each one as an address phase plus a data phase.
module bus_initiator #(
  parameter int BITW  = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     n_reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [BITW-1:0]          req_addr,
  input  logic [BITW-1:0]          req_wdata,
  output logic                     rsp_valid,
  output logic [BITW-1:0]          rsp_data,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     busy,
  output logic                     enable,
  output logic                     rw,
  inout  wire  [BITW-1:0]          bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * BITW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RDATA,
    S_TURN,
    S_WDATA
  } state_t;

  state_t          r_state;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_cur_we;
  logic [BITW-1:0] r_cur_wdata;
  logic            r_enable;
  logic            r_rw;
  logic            r_bus_oe;
  logic [BITW-1:0] r_bus_out;
  logic            r_rsp_valid;
  logic [BITW-1:0] r_rsp_data;

  logic            w_push;
  logic            w_pop;
  logic            w_can_dispatch;
  logic [EW-1:0]   w_head;
  logic            w_head_we;
  logic [BITW-1:0] w_head_addr;
  logic [BITW-1:0] w_head_wdata;

  assign req_ready = (r_count != CW'(DEPTH));
  assign pending   = r_count;
  assign busy      = (r_state != S_IDLE) || (r_count != '0);
  assign enable    = r_enable;
  assign rw        = r_rw;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign bus       = r_bus_oe ? r_bus_out : {BITW{1'bz}};

  // IDLE, TURN and WDATA are the only states from which a new request may start.
  assign w_can_dispatch = (r_state == S_IDLE) || (r_state == S_TURN) || (r_state == S_WDATA);
  assign w_push         = req_valid && req_ready;
  assign w_pop          = w_can_dispatch && (r_count != '0);

  assign w_head       = r_mem[r_rptr];
  assign w_head_we    = w_head[EW-1];
  assign w_head_addr  = w_head[2*BITW-1:BITW];
  assign w_head_wdata = w_head[BITW-1:0];

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= {req_we, req_addr, req_wdata};
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= S_IDLE;
      r_cur_we    <= 1'b0;
      r_cur_wdata <= '0;
      r_enable    <= 1'b0;
      r_rw        <= 1'b0;
      r_bus_oe    <= 1'b0;
      r_bus_out   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_ADDR: begin
          if (r_cur_we) begin
            r_state   <= S_WDATA;
            r_bus_out <= r_cur_wdata;
          end else begin
            r_state  <= S_RDATA;
            r_rw     <= 1'b0;
            r_bus_oe <= 1'b0;
          end
        end
        S_RDATA: begin
          r_state     <= S_TURN;
          r_enable    <= 1'b0;
          r_rsp_data  <= bus;
          r_rsp_valid <= 1'b1;
        end
        default: begin
          if (w_pop) begin
            r_state     <= S_ADDR;
            r_cur_we    <= w_head_we;
            r_cur_wdata <= w_head_wdata;
            r_enable    <= 1'b1;
            r_rw        <= w_head_we;
            r_bus_oe    <= 1'b1;
            r_bus_out   <= w_head_addr;
          end else begin
            r_state  <= S_IDLE;
            r_enable <= 1'b0;
            r_rw     <= 1'b0;
            r_bus_oe <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator with a two-phase ram responder on the shared bus.
module tb_bus_initiator;

  logic       clock;
  logic       n_reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [2:0] pending;
  logic       busy;
  logic       enable;
  logic       rw;
  wire  [7:0] bus;

  int ncmp;
  int nfail;
  int cyc;
  int n_cont;
  logic [2:0] full_pending;

  bus_initiator #(.BITW(8), .DEPTH(4)) dut (
    .clock     (clock),
    .n_reset   (n_reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .pending   (pending),
    .busy      (busy),
    .enable    (enable),
    .rw        (rw),
    .bus       (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Released bus reads back as all ones.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (bus[g]);
  end

  // Ram responder: latch address on first enabled edge, data on the second.
  logic [7:0] mem [256];
  logic       m_phase;
  logic       m_rw;
  logic [7:0] m_addr;
  logic [7:0] wlog [64];
  logic [5:0] wlog_n;
  logic       m_drv;

  always @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      m_phase <= 1'b0;
      m_rw    <= 1'b0;
      m_addr  <= 8'h00;
      wlog_n  <= 6'd0;
    end else if (enable) begin
      if (!m_phase) begin
        m_phase <= 1'b1;
        m_addr  <= bus;
        m_rw    <= rw;
      end else begin
        m_phase <= 1'b0;
        if (m_rw) begin
          mem[m_addr]  <= bus;
          wlog[wlog_n] <= m_addr;
          wlog_n       <= wlog_n + 6'd1;
        end
      end
    end else begin
      m_phase <= 1'b0;
    end
  end

  assign m_drv = enable && m_phase && !m_rw;
  assign bus   = m_drv ? mem[m_addr] : 8'hzz;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (m_drv && dut.r_bus_oe) n_cont <= n_cont + 1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic push(input logic we, input logic [7:0] a, input logic [7:0] d);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin
      full_pending = pending;
      tick();
      n++;
    end
    if (n >= 50) check("push_timeout", 8'd0, 8'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [7:0] d, output int c);
    int n;
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("rsp_timeout", 8'd0, 8'd1);
    d = rsp_data;
    c = cyc;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("idle_timeout", 8'd0, 8'd1);
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    int c;
    push(1'b0, a, 8'h00);
    wait_rsp(d, c);
    check(tag, d, exp);
    tick();
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d1;
    logic [7:0] d2;
    int c0;
    int c1;
    int c2;
    int base;
    ncmp = 0;
    nfail = 0;
    n_cont = 0;
    cyc = 0;
    full_pending = 3'd0;
    n_reset = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = 8'h00;
    req_wdata = 8'h00;
    repeat (2) @(negedge clock);

    check("rst_enable", {7'd0, enable}, 8'd0);
    check("rst_rw", {7'd0, rw}, 8'd0);
    check("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_pending", {5'd0, pending}, 8'd0);
    check("rst_ready", {7'd0, req_ready}, 8'd1);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_bus", bus, 8'hFF);
    n_reset = 1'b1;
    tick();

    // Single write
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h3C; req_wdata = 8'hA5;
    tick();
    req_valid = 1'b0;
    check("w_pending", {5'd0, pending}, 8'd1);
    check("w_pre_enable", {7'd0, enable}, 8'd0);
    tick();
    check("w_addr_enable", {7'd0, enable}, 8'd1);
    check("w_addr_rw", {7'd0, rw}, 8'd1);
    check("w_addr_bus", bus, 8'h3C);
    tick();
    check("w_data_enable", {7'd0, enable}, 8'd1);
    check("w_data_rw", {7'd0, rw}, 8'd1);
    check("w_data_bus", bus, 8'hA5);
    check("w_data_rsp", {7'd0, rsp_valid}, 8'd0);
    tick();
    check("w_end_enable", {7'd0, enable}, 8'd0);
    check("w_end_busy", {7'd0, busy}, 8'd0);
    check("w_end_rsp", {7'd0, rsp_valid}, 8'd0);
    check("w_mem", mem[8'h3C], 8'hA5);

    push(1'b1, 8'h3C, 8'h5A);
    wait_idle();

    // Single read
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h3C; req_wdata = 8'h00;
    tick();
    req_valid = 1'b0;
    tick();
    check("r_addr_enable", {7'd0, enable}, 8'd1);
    check("r_addr_rw", {7'd0, rw}, 8'd0);
    check("r_addr_bus", bus, 8'h3C);
    tick();
    check("r_data_enable", {7'd0, enable}, 8'd1);
    check("r_data_rw", {7'd0, rw}, 8'd0);
    check("r_data_bus", bus, 8'h5A);
    check("r_data_rsp", {7'd0, rsp_valid}, 8'd0);
    tick();
    check("r_turn_enable", {7'd0, enable}, 8'd0);
    check("r_turn_rsp_valid", {7'd0, rsp_valid}, 8'd1);
    check("r_turn_rsp_data", rsp_data, 8'h5A);
    check("r_turn_bus", bus, 8'hFF);
    tick();
    check("r_idle_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    check("r_idle_rsp_data", rsp_data, 8'h5A);
    check("r_idle_busy", {7'd0, busy}, 8'd0);

    // Fill and backpressure: two reads stall the queue behind five writes
    base = int'(wlog_n);
    full_pending = 3'd0;
    push(1'b0, 8'h00, 8'h00);
    push(1'b0, 8'h01, 8'h00);
    for (int i = 0; i < 5; i++) push(1'b1, 8'(i), 8'(8'hA0 + i));
    check("fill_full_pending", {5'd0, full_pending}, 8'd4);
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fill_order_%0d", i), wlog[6'(base + i)], 8'(i));
      check($sformatf("fill_mem_%0d", i), mem[8'(i)], 8'(8'hA0 + i));
    end

    // Mixed back-to-back
    c0 = cyc;
    push(1'b1, 8'h10, 8'h11);
    push(1'b0, 8'h10, 8'h00);
    push(1'b1, 8'h20, 8'h22);
    push(1'b0, 8'h20, 8'h00);
    wait_rsp(d1, c1);
    tick();
    wait_rsp(d2, c2);
    check("mix_rd1", d1, 8'h11);
    check("mix_rd2", d2, 8'h22);
    check("mix_lat1", 8'(c1 - c0), 8'd6);
    check("mix_gap", 8'(c2 - c1), 8'd5);
    wait_idle();

    // Pointer wrap over three times the depth, with push/pop at pending=1
    for (int i = 0; i < 12; i++) begin
      push(1'b1, 8'(8'h40 + i), 8'(8'hC0 + i));
      if (i == 1) check("pushpop_pending", {5'd0, pending}, 8'd1);
    end
    wait_idle();
    for (int i = 0; i < 12; i++) do_read($sformatf("wrap_rd_%0d", i), 8'(8'h40 + i), 8'(8'hC0 + i));

    // Reset in the middle of a read, with a write still queued
    push(1'b0, 8'h3C, 8'h00);
    push(1'b1, 8'h3C, 8'hFF);
    tick();
    check("mid_rdata_enable", {7'd0, enable}, 8'd1);
    check("mid_rdata_pending", {5'd0, pending}, 8'd1);
    #1 n_reset = 1'b0;
    #1;
    check("arst_enable", {7'd0, enable}, 8'd0);
    check("arst_bus", bus, 8'hFF);
    check("arst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    check("arst_pending", {5'd0, pending}, 8'd0);
    check("arst_ready", {7'd0, req_ready}, 8'd1);
    @(negedge clock);
    check("arst_rsp_hold", {7'd0, rsp_valid}, 8'd0);
    n_reset = 1'b1;
    tick();
    check("post_rst_enable", {7'd0, enable}, 8'd0);
    check("post_rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    do_read("post_rst_read", 8'h3C, 8'h5A);

    check("no_contention", {7'd0, (n_cont == 0)}, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/bus_initiator.md
Name: bus_initiator

Overview:
- Initiator (master) side of the shared single-bus memory protocol, i.e. the block that drives `enable`/`rw`/`bus` toward the ram responder.
- Accepts read/write requests from a core-side valid/ready port and buffers them in a small FIFO.
- Sequences each request as an address phase followed by a data phase, and returns read data on a response port.
- Sits between the control unit and the ram on the tri-state bus.

Parameters:
- BITW, 8: width of the bus, address and data.
- DEPTH, 4: request FIFO entries; power of two, at least 2.

Ports:
- clock  input  1  rising-edge clock
- n_reset  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  FIFO can accept; equals !full, derived from registered count
- req_we  input  1  1 = write, 0 = read
- req_addr  input  BITW  target address
- req_wdata  input  BITW  write data, ignored for reads
- rsp_valid  output  1  one-cycle pulse: rsp_data holds read result
- rsp_data  output  BITW  last read result, held until the next read completes
- pending  output  $clog2(DEPTH)+1  FIFO occupancy
- busy  output  1  state != IDLE or pending != 0
- enable  output  1  bus transaction strobe to ram
- rw  output  1  0 = read, 1 = write, to ram
- bus  inout  BITW  shared bus; driven only when bus_oe=1, otherwise 'z

Behaviour:
- Reset (async, n_reset=0):
  - state = IDLE, FIFO empty, pending = 0.
  - enable = 0, rw = 0, bus_oe = 0 (bus released immediately, no clock needed).
  - rsp_valid = 0, rsp_data = 0, req_ready = 1.
- All outputs are registered. bus = bus_oe ? bus_out : 'z.
- FIFO:
  - Push when req_valid && req_ready. Pop when the FSM dispatches.
  - Push and pop in the same cycle: count unchanged.
  - Push while full never happens, because req_ready = 0. A req_valid asserted while full is held by the source, not dropped.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ADDR, RDATA, TURN, WDATA.
- IDLE:
  - enable = 0, bus_oe = 0.
  - If the FIFO is non-empty: pop the head into cur_we/cur_addr/cur_wdata and go to ADDR.
  - A request pushed into an empty FIFO is dispatched on the following edge, at the earliest.
- ADDR:
  - enable = 1, rw = cur_we, bus_oe = 1, bus = cur_addr.
  - The ram samples the address at the end of this cycle.
  - Next state: WDATA if cur_we, else RDATA.
- RDATA:
  - enable = 1, rw = 0, bus_oe = 0; the ram drives the bus.
  - At the closing edge: rsp_data <= bus, rsp_valid = 1 for exactly the next cycle.
  - Next state: TURN.
- TURN:
  - enable = 0, bus_oe = 0: one dead cycle for bus turnaround.
  - If the FIFO is non-empty: pop and go to ADDR, else go to IDLE.
- WDATA:
  - enable = 1, rw = 1, bus_oe = 1, bus = cur_wdata.
  - The ram writes at the closing edge.
  - If the FIFO is non-empty: pop and go to ADDR, else go to IDLE.
- Latency from first dispatch edge:
  - Read: rsp_valid 2 cycles after entering ADDR.
  - Back-to-back throughput: write = 2 cycles each, read = 3 cycles each.
- Bus ownership invariant: bus_oe = 1 only in ADDR or WDATA.
  - Never in two consecutive cycles across a read boundary.
  - Never while enable = 1 && rw = 0 outside ADDR.
- Writes carry no response; rsp_valid stays 0 for them.
- Requests complete strictly in FIFO order.
- Reset mid-transaction: the transaction is abandoned, with no rsp_valid pulse. Queued requests are discarded.

Test Plan:
- Single write: push we=1 addr=0x3C wdata=0xA5.
  - Required: enable=1,rw=1,bus=0x3C for one cycle, then enable=1,rw=1,bus=0xA5 for one cycle, then enable=0.
  - No rsp_valid; busy falls after the WDATA cycle.
- Single read: responder model returns 0x5A for addr 0x3C.
  - Required: bus=0x3C with rw=0, then bus released, then rsp_valid=1 with rsp_data=0x5A.
  - One TURN cycle with enable=0.
- Fill and backpressure with DEPTH=4, ram model stalled by long prior reads:
  - Push 5 writes → pending reaches 4, req_ready=0, 5th held by source.
  - All 5 complete in order at addresses 0x00..0x04.
- Mixed back-to-back: W(0x10,0x11), R(0x10), W(0x20,0x22), R(0x20).
  - Required: reads return 0x11 then 0x22.
  - ADDR follows WDATA/TURN with no IDLE cycle.
  - No cycle where bus_oe=1 and the model drives.
- Simultaneous push/pop at pending=1: pending stays 1; pointer wrap verified across at least 3×DEPTH requests.
- Async reset asserted mid-RDATA:
  - Required: enable=0 and bus='z before the next clock edge, no rsp_valid, pending=0, req_ready=1.
  - After release, a read of 0x3C completes normally.
